branch_resolve_tracker: RTL

Tracks every prediction issued by the global branch predictor until the execute stage resolves that branch. It returns the actual outcome to the predictor as a training `branch`/`update` pair and detects mispredictions. On a misprediction it drives a fixed-length pipeline flush and discards all younger in-flight predictions. It sits between the predictor's `prediction` output (fetch side) and the execute stage's branch-resolution result.

---
 rtl/branch_resolve_tracker_pkg.sv | 19 +
 rtl/bp_pred_fifo.sv | 61 ++++++
 rtl/branch_resolve_tracker.sv | 121 ++++++++++++
 3 files changed

// File: rtl/branch_resolve_tracker_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bp_pkg : shared types and default constants for branch_resolve_tracker
// Revision: 1.0
// ============================================================================
package bp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } bp_state_e;

  localparam int BP_DEPTH        = 4;
  localparam int BP_FLUSH_CYCLES = 2;
  localparam int BP_CNT_W        = 16;

endpackage
`default_nettype wire

// File: rtl/bp_pred_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bp_pred_fifo : 1-bit synchronous FIFO of predicted outcomes; clear beats push
// Revision: 1.0
// ============================================================================
module bp_pred_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic                       data_i,
  output logic                       data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// branch_resolve_tracker : matches predictions to resolutions, trains the
// predictor and flushes the pipeline on a misprediction.   Revision: 1.0
// ============================================================================
module branch_resolve_tracker
  import bp_pkg::*;
#(
  parameter int DEPTH        = BP_DEPTH,
  parameter int CNT_W        = BP_CNT_W,
  parameter int FLUSH_CYCLES = BP_FLUSH_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       branch,
  output logic                       update,
  output logic                       mispredict,
  output logic                       flush,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [CNT_W-1:0]           miss_cnt
);

  localparam int FCW = $clog2(FLUSH_CYCLES) + 1;

  bp_state_e        state_q, state_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic             do_push;
  logic             do_resolve;
  logic             wrong;
  logic             update_q;
  logic             branch_q;
  logic             mispredict_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] miss_q;

  assign pred_ready = !reset && (state_q == ST_IDLE) && !fifo_full;
  assign do_push    = pred_valid && pred_ready;
  assign do_resolve = res_valid && (state_q == ST_IDLE) && !fifo_empty;
  assign wrong      = do_resolve && (fifo_head != res_taken);

  bp_pred_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (do_push),
    .pop_i   (do_resolve),
    .clear_i (wrong),
    .data_i  (pred_taken),
    .data_o  (fifo_head),
    .count_o (outstanding),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Flush lasts FLUSH_CYCLES cycles: counter runs FLUSH_CYCLES-1 down to 0.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wrong) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCW'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_IDLE;
        else              fcnt_d  = fcnt_q - FCW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_q     <= 1'b0;
      branch_q     <= 1'b0;
      mispredict_q <= 1'b0;
      total_q      <= '0;
      miss_q       <= '0;
    end else begin
      update_q     <= do_resolve;
      mispredict_q <= wrong;
      if (do_resolve) begin
        branch_q <= res_taken;
        if (total_q != '1) total_q <= total_q + CNT_W'(1);
      end
      if (wrong && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
    end
  end

  assign update     = update_q;
  assign branch     = branch_q;
  assign mispredict = mispredict_q;
  assign flush      = (state_q == ST_FLUSH);
  assign total_cnt  = total_q;
  assign miss_cnt   = miss_q;

endmodule
`default_nettype wire
